// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-file target.
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV,
        S_DEV_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WR,
        S_WR_ACK,
        S_RD,
        S_MACK,
        S_IGNORE
    } sccb_state_e;

    localparam logic [6:0] SCCB_DEV_ADDR   = 7'h21;
    localparam logic [7:0] SCCB_WRITE_ADDR = 8'h42;
    localparam logic [7:0] SCCB_READ_ADDR  = 8'h43;

endpackage

// File: rtl/sccb_line_filter.sv
// Synchronizes a raw bus pin, rejects pulses shorter than FILTER_LEN clks,
// and reports one-clk rise/fall strobes on the filtered level.
module sccb_line_filter #(
    parameter int   FILTER_LEN = 4,
    parameter logic RST_VAL    = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1_q, sync2_q, filt_q, prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            filt_q  <= RST_VAL;
            prev_q  <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            // Any sample agreeing with the current level restarts the run.
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = filt_q;
    assign rise_o  = filt_q & ~prev_q;
    assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C target with an 8-bit register file: 3-phase writes, 2-phase
// write + 2-phase read, fabric read port and write strobe.
module sccb_slave_regfile
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = SCCB_DEV_ADDR,
    parameter int         DEPTH      = 64,
    parameter int         FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_system_n,
    input  logic       camera_data_scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] cfg_rd_addr,
    output logic [7:0] cfg_rd_data,
    output logic       reg_wr_strobe,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i  (clk),
        .rst_ni (reset_system_n),
        .pin_i  (camera_data_scl),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i  (clk),
        .rst_ni (reset_system_n),
        .pin_i  (sda_in),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    sccb_state_e state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  regs_q [DEPTH];

    logic       start_cond, stop_cond;
    logic       ptr_ok, reg_we;
    logic [7:0] byte_in, rd_byte;

    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;
    assign byte_in    = {shift_q[6:0], sda_lvl};
    assign ptr_ok     = ({1'b0, ptr_q} < DEPTH_W);
    // Unimplemented registers read as a released line.
    assign rd_byte    = ptr_ok ? regs_q[ptr_q[AW-1:0]] : 8'hFF;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;

        if (start_cond) begin
            state_d  = S_DEV;
            bitcnt_d = 3'd0;
            sda_oe_d = 1'b0;
            mack_d   = 1'b0;
        end else if (stop_cond) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            mack_d   = 1'b0;
        end else begin
            case (state_q)
                S_DEV, S_SUB, S_WR: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            case (state_q)
                                S_DEV: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_d = S_DEV_ACK;
                                        rw_d    = byte_in[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = S_IGNORE;
                                    end
                                end
                                S_SUB: begin
                                    ptr_d   = byte_in;
                                    state_d = S_SUB_ACK;
                                end
                                default: begin
                                    if (ptr_ok) begin
                                        reg_we    = 1'b1;
                                        strobe_d  = 1'b1;
                                        wr_addr_d = ptr_q;
                                        wr_data_d = byte_in;
                                    end
                                    ptr_d   = ptr_q + 8'd1;
                                    state_d = S_WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First fall after the 8th bit starts the ACK, the next one ends it.
                S_DEV_ACK, S_SUB_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = 3'd0;
                            if (state_q == S_DEV_ACK && rw_q) begin
                                state_d  = S_RD;
                                shift_d  = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else if (state_q == S_DEV_ACK) begin
                                state_d = S_SUB;
                            end else begin
                                state_d = S_WR;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_MACK;
                        end else begin
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                S_MACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_d = S_IGNORE;
                        end else begin
                            ptr_d  = ptr_q + 8'd1;
                            mack_d = 1'b1;
                        end
                    end else if (scl_fall && mack_q) begin
                        mack_d   = 1'b0;
                        state_d  = S_RD;
                        bitcnt_d = 3'd0;
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_system_n) begin
        if (!reset_system_n) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= 3'd0;
            shift_q   <= 8'd0;
            ptr_q     <= 8'd0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset_system_n) begin
        if (!reset_system_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'd0;
        end else if (reg_we) begin
            regs_q[ptr_q[AW-1:0]] <= byte_in;
        end
    end

    assign cfg_rd_data   = ({1'b0, cfg_rd_addr} < DEPTH_W) ? regs_q[cfg_rd_addr[AW-1:0]] : 8'h00;
    assign sda_oe        = sda_oe_q;
    assign busy          = busy_q;
    assign reg_wr_strobe = strobe_q;
    assign reg_wr_addr   = wr_addr_q;
    assign reg_wr_data   = wr_data_q;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Bench: bit-banged SCCB master, table vectors, corner sequences and random
// transactions checked against a register-array model.
module tb_sccb_slave_regfile;
    import sccb_pkg::*;

    localparam int DEPTH      = 64;
    localparam int FILTER_LEN = 4;
    localparam int Q          = 8;   // quarter SCL period in clks

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] cfg_rd_addr, cfg_rd_data;
    logic       reg_wr_strobe;
    logic [7:0] reg_wr_addr, reg_wr_data;
    logic       busy;

    assign sda_line = sda_m & ~sda_oe;

    sccb_slave_regfile #(.DEV_ADDR(7'h21), .DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN)) dut (
        .clk            (clk),
        .reset_system_n (rst_n),
        .camera_data_scl(scl_m),
        .sda_in         (sda_line),
        .sda_oe         (sda_oe),
        .cfg_rd_addr    (cfg_rd_addr),
        .cfg_rd_data    (cfg_rd_data),
        .reg_wr_strobe  (reg_wr_strobe),
        .reg_wr_addr    (reg_wr_addr),
        .reg_wr_data    (reg_wr_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    int cyc = 0;
    int strobe_cnt = 0, strobe_cyc = 0, oe_cnt = 0, oe_rise_cyc = 0;
    int last_rise_cyc = 0, last_fall_cyc = 0, byte_rise_cyc = 0, ack_fall_cyc = 0;
    logic oe_prev = 1'b0;
    logic [7:0] mregs [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_wr_strobe) begin
            strobe_cnt++;
            strobe_cyc = cyc;
        end
        if (sda_oe) oe_cnt++;
        if (sda_oe && !oe_prev) oe_rise_cyc = cyc;
        oe_prev = sda_oe;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish within time budget");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cyc(input logic b, input logic gl, output logic s, output logic oe);
        clks(Q); sda_m = b;
        clks(Q); scl_m = 1'b1; last_rise_cyc = cyc;
        clks(Q); s = sda_line; oe = sda_oe;
        if (gl) begin
            clks(2); scl_m = 1'b0; clks(1); scl_m = 1'b1; clks(Q - 3);
        end else begin
            clks(Q);
        end
        scl_m = 1'b0; last_fall_cyc = cyc;
    endtask

    task automatic start_c();
        clks(Q); sda_m = 1'b1;
        clks(Q); scl_m = 1'b1;
        clks(2 * Q); sda_m = 1'b0;
        clks(2 * Q); scl_m = 1'b0;
    endtask

    task automatic stop_c();
        clks(Q); sda_m = 1'b0;
        clks(Q); scl_m = 1'b1;
        clks(2 * Q); sda_m = 1'b1;
        clks(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int gl, output logic ack);
        logic s, o;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], (i == gl), s, o);
        byte_rise_cyc = last_rise_cyc;
        ack_fall_cyc  = last_fall_cyc;
        bit_cyc(1'b1, 1'b0, s, o);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe_m);
        logic s, o;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, 1'b0, s, o);
            d[i] = s;
        end
        bit_cyc(mack, 1'b0, s, o);
        oe_m = o;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] d [4], input int n);
        logic [7:0] p;
        p = a;
        for (int k = 0; k < n; k++) begin
            if (p < DEPTH) mregs[p] = d[k];
            p = p + 8'd1;
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a, input int k);
        logic [7:0] p;
        p = a + 8'(k);
        return (p < DEPTH) ? mregs[p] : 8'hFF;
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d [4], input int n, output int nk);
        logic ack;
        nk = 0;
        start_c();
        write_byte(SCCB_WRITE_ADDR, -1, ack); if (!ack) nk++;
        write_byte(a, -1, ack);               if (!ack) nk++;
        for (int k = 0; k < n; k++) begin
            write_byte(d[k], -1, ack);        if (!ack) nk++;
        end
        stop_c();
        model_write(a, d, n);
    endtask

    task automatic bus_read(input logic [7:0] a, input int n, output logic [7:0] q [4],
                            output int nk, output int oe_m);
        logic ack, o;
        nk = 0; oe_m = 0;
        start_c();
        write_byte(SCCB_WRITE_ADDR, -1, ack); if (!ack) nk++;
        write_byte(a, -1, ack);               if (!ack) nk++;
        start_c();
        write_byte(SCCB_READ_ADDR, -1, ack);  if (!ack) nk++;
        for (int k = 0; k < n; k++) begin
            read_byte((k == n - 1), q[k], o);
            if (o) oe_m++;
        end
        stop_c();
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         exp_strb;
        logic [7:0] exp_fab;
        logic [7:0] exp_bus;
    } vec_t;

    initial begin
        vec_t       tbl [7];
        logic [7:0] d [4];
        logic [7:0] q [4];
        logic       ack;
        int         nk, oe_m, s0, o0, n, a;

        tbl[0] = '{8'h14, 8'h24, 1, 8'h24, 8'h24};
        tbl[1] = '{8'h12, 8'h2C, 1, 8'h2C, 8'h2C};
        tbl[2] = '{8'h00, 8'hFF, 1, 8'hFF, 8'hFF};
        tbl[3] = '{8'h3F, 8'hA5, 1, 8'hA5, 8'hA5};
        tbl[4] = '{8'h40, 8'h77, 0, 8'h00, 8'hFF};
        tbl[5] = '{8'hFF, 8'h01, 0, 8'h00, 8'hFF};
        tbl[6] = '{8'h00, 8'h00, 1, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) mregs[i] = 8'h00;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; cfg_rd_addr = 8'h14;
        clks(4);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_strobe", reg_wr_strobe, 0);
        chk("rst_wr_addr", reg_wr_addr, 0);
        chk("rst_wr_data", reg_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fabric", cfg_rd_data, 0);
        rst_n = 1'b1;
        clks(10);

        // Write 0x42,0x14,0x24: ACK timing, busy, strobe, busy drop at STOP.
        s0 = strobe_cnt;
        start_c();
        write_byte(SCCB_WRITE_ADDR, -1, ack);
        chk("seq1_dev_ack", ack, 1);
        chk("seq1_ack_latency", oe_rise_cyc - ack_fall_cyc, FILTER_LEN + 3);
        chk("seq1_busy", busy, 1);
        write_byte(8'h14, -1, ack); chk("seq1_sub_ack", ack, 1);
        write_byte(8'h24, -1, ack); chk("seq1_data_ack", ack, 1);
        chk("seq1_strobe_latency", strobe_cyc - byte_rise_cyc, FILTER_LEN + 3);
        stop_c();
        mregs[8'h14] = 8'h24;
        clks(4);
        chk("seq1_busy_after_stop", busy, 0);
        chk("seq1_strobes", strobe_cnt - s0, 1);
        chk("seq1_wr_addr", reg_wr_addr, 8'h14);
        chk("seq1_wr_data", reg_wr_data, 8'h24);

        for (int i = 0; i < 7; i++) begin
            s0 = strobe_cnt;
            d[0] = tbl[i].data;
            bus_write(tbl[i].addr, d, 1, nk);
            chk("tbl_wr_acks_missing", nk, 0);
            chk("tbl_strobes", strobe_cnt - s0, tbl[i].exp_strb);
            if (tbl[i].exp_strb == 1) begin
                chk("tbl_wr_addr", reg_wr_addr, tbl[i].addr);
                chk("tbl_wr_data", reg_wr_data, tbl[i].data);
            end
            cfg_rd_addr = tbl[i].addr; #1;
            chk("tbl_fabric", cfg_rd_data, tbl[i].exp_fab);
            bus_read(tbl[i].addr, 1, q, nk, oe_m);
            chk("tbl_rd_acks_missing", nk, 0);
            chk("tbl_bus_read", q[0], tbl[i].exp_bus);
            chk("tbl_nack_oe", oe_m, 0);
        end

        // Wrong device address: never driven, no strobe, not busy.
        s0 = strobe_cnt; o0 = oe_cnt;
        start_c();
        write_byte(8'h60, -1, ack); chk("wrongdev_ack", ack, 0);
        chk("wrongdev_busy", busy, 0);
        write_byte(8'h14, -1, ack);
        write_byte(8'h24, -1, ack);
        stop_c();
        chk("wrongdev_oe", oe_cnt - o0, 0);
        chk("wrongdev_strobes", strobe_cnt - s0, 0);

        // Burst across the end of the register file.
        s0 = strobe_cnt;
        d[0] = 8'hAA; d[1] = 8'hBB;
        bus_write(8'h3F, d, 2, nk);
        chk("burst_acks_missing", nk, 0);
        chk("burst_strobes", strobe_cnt - s0, 1);
        chk("burst_wr_addr", reg_wr_addr, 8'h3F);
        chk("burst_wr_data", reg_wr_data, 8'hAA);
        cfg_rd_addr = 8'h3F; #1;
        chk("burst_fab_3f", cfg_rd_data, 8'hAA);
        cfg_rd_addr = 8'h40; #1;
        chk("burst_fab_40", cfg_rd_data, 8'h00);

        // One-clk SCL glitch while SCL is high inside the data byte.
        s0 = strobe_cnt;
        start_c();
        write_byte(SCCB_WRITE_ADDR, -1, ack);
        write_byte(8'h20, -1, ack);
        write_byte(8'h5A, 4, ack); chk("glitch_ack", ack, 1);
        stop_c();
        mregs[8'h20] = 8'h5A;
        chk("glitch_strobes", strobe_cnt - s0, 1);
        cfg_rd_addr = 8'h20; #1;
        chk("glitch_fabric", cfg_rd_data, 8'h5A);

        // Randomized transactions against the model.
        for (int t = 0; t < 10; t++) begin
            a = $urandom_range(0, 75);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
                bus_write(8'(a), d, n, nk);
                chk("rnd_wr_acks_missing", nk, 0);
            end else begin
                bus_read(8'(a), n, q, nk, oe_m);
                chk("rnd_rd_acks_missing", nk, 0);
                for (int k = 0; k < n; k++) chk("rnd_bus_read", q[k], model_read(8'(a), k));
            end
            a = $urandom_range(0, 80);
            cfg_rd_addr = 8'(a); #1;
            chk("rnd_fabric", cfg_rd_data, (a < DEPTH) ? mregs[a] : 8'h00);
        end

        // Asynchronous reset while the target drives a read bit low.
        start_c();
        write_byte(SCCB_WRITE_ADDR, -1, ack);
        write_byte(8'h12, -1, ack);
        start_c();
        write_byte(SCCB_READ_ADDR, -1, ack);
        clks(Q);
        chk("rstrd_oe_before", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1 chk("rstrd_oe_async", sda_oe, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        clks(4);
        cfg_rd_addr = 8'h12; #1;
        chk("rstrd_fabric_cleared", cfg_rd_data, 8'h00);
        chk("rstrd_busy", busy, 0);
        for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
        rst_n = 1'b1;
        clks(10);
        d[0] = 8'h9C;
        bus_write(8'h05, d, 1, nk);
        chk("rstrd_next_wr_acks", nk, 0);
        bus_read(8'h05, 1, q, nk, oe_m);
        chk("rstrd_next_read", q[0], 8'h9C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
